// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter feeding the register file's single write port.
// Define REGFILE_ARB_RR_EN for round-robin conflict resolution; otherwise A has fixed priority.
module regfile_write_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             ReqValidA,
  output logic             ReqReadyA,
  input  logic [4:0]       ReqAddrA,
  input  logic [31:0]      ReqDataA,
  input  logic             ReqValidB,
  output logic             ReqReadyB,
  input  logic [4:0]       ReqAddrB,
  input  logic [31:0]      ReqDataB,
  output logic             RegWrite,
  output logic [4:0]       WriteRegister,
  output logic [31:0]      WriteData,
  output logic             Busy,
  output logic [CNT_W-1:0] WriteCount
);

  logic        full_a, full_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] data_a, data_b;
  logic        grant_a, grant_b;
  logic        accept_a, accept_b;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;

`ifdef REGFILE_ARB_RR_EN
  logic last_grant;

  // On a conflict the requester that did not win last time is served.
  always_comb begin
    grant_a = full_a & (!full_b | last_grant);
    grant_b = full_b & (!full_a | !last_grant);
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN)      last_grant <= 1'b1;
    else if (grant_a) last_grant <= 1'b0;
    else if (grant_b) last_grant <= 1'b1;
  end
`else
  always_comb begin
    grant_a = full_a;
    grant_b = full_b & !full_a;
  end
`endif

  // Ready depends only on flops, so a buffer being drained can refill on the same edge.
  assign ReqReadyA = !full_a | grant_a;
  assign ReqReadyB = !full_b | grant_b;
  assign accept_a  = ReqValidA & ReqReadyA;
  assign accept_b  = ReqValidB & ReqReadyB;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      full_a <= 1'b0;
      full_b <= 1'b0;
    end else begin
      full_a <= accept_a | (full_a & !grant_a);
      full_b <= accept_b | (full_b & !grant_b);
    end
  end

  // Buffer payload is only meaningful while its full bit is set.
  always_ff @(posedge Clk) begin
    if (accept_a) begin
      addr_a <= ReqAddrA;
      data_a <= ReqDataA;
    end
    if (accept_b) begin
      addr_b <= ReqAddrB;
      data_b <= ReqDataB;
    end
  end

  always_comb begin
    sel_addr = grant_a ? addr_a : addr_b;
    sel_data = grant_a ? data_a : data_b;
  end

  // Output stage: register 0 writes retire here without asserting RegWrite.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
      WriteCount    <= '0;
    end else if (grant_a | grant_b) begin
      WriteRegister <= sel_addr;
      WriteData     <= sel_data;
      RegWrite      <= (sel_addr != 5'd0);
      if (sel_addr != 5'd0) WriteCount <= WriteCount + CNT_W'(1);
    end else begin
      RegWrite <= 1'b0;
    end
  end

  assign Busy = full_a | full_b | RegWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued with their due cycle.
module tb_regfile_write_arbiter;

  localparam int CNT_W = 16;

  logic             Clk;
  logic             ResetN;
  logic             ReqValidA, ReqReadyA;
  logic [4:0]       ReqAddrA;
  logic [31:0]      ReqDataA;
  logic             ReqValidB, ReqReadyB;
  logic [4:0]       ReqAddrB;
  logic [31:0]      ReqDataB;
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [31:0]      WriteData;
  logic             Busy;
  logic [CNT_W-1:0] WriteCount;

  regfile_write_arbiter #(.CNT_W(CNT_W)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .ReqValidA(ReqValidA), .ReqReadyA(ReqReadyA), .ReqAddrA(ReqAddrA), .ReqDataA(ReqDataA),
    .ReqValidB(ReqValidB), .ReqReadyB(ReqReadyB), .ReqAddrB(ReqAddrB), .ReqDataB(ReqDataB),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .Busy(Busy), .WriteCount(WriteCount)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } wr_t;

  wr_t         sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] rf [32] = '{default: 32'd0};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Plain memory model of the register file, including r0.
  always @(posedge Clk) if (RegWrite) rf[WriteRegister] <= WriteData;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input int due);
    wr_t e;
    e.addr = a; e.data = d; e.due = due;
    sb.push_back(e);
  endtask

  always @(negedge Clk) begin
    if (RegWrite) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(RegWrite), 64'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 64'(WriteRegister), 64'(e.addr));
        check("wr_data", 64'(WriteData), 64'(e.data));
        check("wr_cycle", 64'(cyc), 64'(e.due));
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      check("missing_write", 64'(RegWrite), 64'd1);
      void'(sb.pop_front());
    end
  end

  task automatic do_reset();
    @(negedge Clk);
    ResetN = 1'b0;
    ReqValidA = 1'b0;
    ReqValidB = 1'b0;
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
  endtask

  initial begin
    int s, c1, na, nb, sa, sbn, it, wc;
    logic acc_a, acc_b;

    ResetN = 1'b0;
    ReqValidA = 1'b1; ReqAddrA = 5'd5; ReqDataA = 32'hDEADBEEF;
    ReqValidB = 1'b1; ReqAddrB = 5'd6; ReqDataB = 32'h1;

    // Reset held with both requesters valid
    repeat (3) @(negedge Clk);
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_count", 64'(WriteCount), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_waddr", 64'(WriteRegister), 64'd0);
    check("rst_wdata", 64'(WriteData), 64'd0);
    check("rst_ready_a", 64'(ReqReadyA), 64'd1);
    check("rst_ready_b", 64'(ReqReadyB), 64'd1);
    ReqValidA = 1'b0; ReqValidB = 1'b0;
    @(negedge Clk);
    ResetN = 1'b1;

    // First write after reset: r5 = DEADBEEF
    @(negedge Clk);
    check("first_ready_a", 64'(ReqReadyA), 64'd1);
    ReqValidA = 1'b1; ReqAddrA = 5'd5; ReqDataA = 32'hDEADBEEF;
    push(5'd5, 32'hDEADBEEF, cyc + 2);
    @(negedge Clk);
    ReqValidA = 1'b0;
    repeat (3) @(negedge Clk);
    check("first_rf5", 64'(rf[5]), 64'hDEADBEEF);
    check("first_count", 64'(WriteCount), 64'd1);

    // Simultaneous A and B
    do_reset();
    @(negedge Clk);
    ReqValidA = 1'b1; ReqAddrA = 5'd3; ReqDataA = 32'h11;
    ReqValidB = 1'b1; ReqAddrB = 5'd4; ReqDataB = 32'h22;
    push(5'd3, 32'h11, cyc + 2);
    push(5'd4, 32'h22, cyc + 3);
    @(negedge Clk);
    ReqValidA = 1'b0; ReqValidB = 1'b0;
    repeat (4) @(negedge Clk);
    check("simul_count", 64'(WriteCount), 64'd2);
    check("simul_rf3", 64'(rf[3]), 64'h11);
    check("simul_rf4", 64'(rf[4]), 64'h22);

    // Same destination: grant order decides the final value
    @(negedge Clk);
    ReqValidA = 1'b1; ReqAddrA = 5'd15; ReqDataA = 32'hAAAA;
    ReqValidB = 1'b1; ReqAddrB = 5'd15; ReqDataB = 32'hBBBB;
    push(5'd15, 32'hAAAA, cyc + 2);
    push(5'd15, 32'hBBBB, cyc + 3);
    @(negedge Clk);
    ReqValidA = 1'b0; ReqValidB = 1'b0;
    repeat (4) @(negedge Clk);
    check("same_reg_rf15", 64'(rf[15]), 64'hBBBB);
    check("same_reg_count", 64'(WriteCount), 64'd4);

    // Continuous contention
    do_reset();
    @(negedge Clk);
    s = cyc;
    c1 = s + 1;
`ifdef REGFILE_ARB_RR_EN
    na = 4; nb = 4;
    for (int i = 0; i < 4; i++) begin
      push(5'(10 + i), 32'hA000_0000 + 32'(i), c1 + 1 + 2 * i);
      push(5'(20 + i), 32'hB000_0000 + 32'(i), c1 + 2 + 2 * i);
    end
`else
    na = 8; nb = 2;
    for (int i = 0; i < 8; i++) push(5'(10 + i), 32'hA000_0000 + 32'(i), c1 + 1 + i);
    for (int j = 0; j < 2; j++) push(5'(20 + j), 32'hB000_0000 + 32'(j), c1 + 9 + j);
`endif
    sa = 0; sbn = 0; it = 0;
    while ((sa < na || sbn < nb) && it < 30) begin
      ReqValidA = (sa < na);
      ReqAddrA  = 5'(10 + sa);
      ReqDataA  = 32'hA000_0000 + 32'(sa);
      ReqValidB = (sbn < nb);
      ReqAddrB  = 5'(20 + sbn);
      ReqDataB  = 32'hB000_0000 + 32'(sbn);
      acc_a = ReqValidA & ReqReadyA;
      acc_b = ReqValidB & ReqReadyB;
`ifndef REGFILE_ARB_RR_EN
      if (it == 4) check("fixed_ready_b_blocked", 64'(ReqReadyB), 64'd0);
`endif
      @(negedge Clk);
      if (acc_a) sa++;
      if (acc_b) sbn++;
      it++;
    end
    ReqValidA = 1'b0; ReqValidB = 1'b0;
    check("contend_sent_a", 64'(sa), 64'(na));
    check("contend_sent_b", 64'(sbn), 64'(nb));
    repeat (4) @(negedge Clk);
    check("contend_count", 64'(WriteCount), 64'(na + nb));

    // Register 0 write
    wc = int'(WriteCount);
    @(negedge Clk);
    check("r0_ready_a", 64'(ReqReadyA), 64'd1);
    ReqValidA = 1'b1; ReqAddrA = 5'd0; ReqDataA = 32'hFFFF_FFFF;
    @(negedge Clk);
    ReqValidA = 1'b0;
    check("r0_busy_held", 64'(Busy), 64'd1);
    repeat (3) @(negedge Clk);
    check("r0_count", 64'(WriteCount), 64'(wc));
    check("r0_rf0", 64'(rf[0]), 64'd0);
    check("r0_waddr", 64'(WriteRegister), 64'd0);
    check("r0_wdata", 64'(WriteData), 64'hFFFF_FFFF);
    check("r0_busy_idle", 64'(Busy), 64'd0);

    // Back-to-back single requester
    do_reset();
    @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      check("b2b_ready_a", 64'(ReqReadyA), 64'd1);
      ReqValidA = 1'b1; ReqAddrA = 5'(i + 1); ReqDataA = 32'h100 + 32'(i);
      push(5'(i + 1), 32'h100 + 32'(i), cyc + 2);
      @(negedge Clk);
    end
    ReqValidA = 1'b0;
    repeat (3) @(negedge Clk);
    check("b2b_count", 64'(WriteCount), 64'd8);
    check("b2b_rf8", 64'(rf[8]), 64'h107);

    // Reset with both buffers full
    @(negedge Clk);
    ReqValidA = 1'b1; ReqAddrA = 5'd30; ReqDataA = 32'h3030;
    ReqValidB = 1'b1; ReqAddrB = 5'd31; ReqDataB = 32'h3131;
    @(negedge Clk);
    ReqValidA = 1'b0; ReqValidB = 1'b0;
    check("mid_busy_before", 64'(Busy), 64'd1);
    #1 ResetN = 1'b0;
    #1;
    check("mid_regwrite", 64'(RegWrite), 64'd0);
    check("mid_busy", 64'(Busy), 64'd0);
    check("mid_count", 64'(WriteCount), 64'd0);
    check("mid_waddr", 64'(WriteRegister), 64'd0);
    check("mid_wdata", 64'(WriteData), 64'd0);
    check("mid_ready_a", 64'(ReqReadyA), 64'd1);
    check("mid_ready_b", 64'(ReqReadyB), 64'd1);
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    repeat (4) @(negedge Clk);
    check("mid_rf30", 64'(rf[30]), 64'd0);
    check("mid_rf31", 64'(rf[31]), 64'd0);
    check("mid_count_after", 64'(WriteCount), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
